// File: rtl/uart_tx_arbiter.sv
// Four-requester round-robin arbiter feeding a single 8N1 UART transmitter.
// Define UART_TX_ARB_PARITY_EN to insert an even-parity bit (8E1 framing).
module uart_tx_arbiter #(
    parameter int CLK_DIV = 625
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  req_valid,
    input  logic [31:0] req_data,
    output logic [3:0]  req_ready,
    output logic [1:0]  grant_id,
    output logic        busy,
    output logic        txd
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_ARB_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    localparam logic [9:0] LAST_CNT = 10'(CLK_DIV - 1);

    state_t      r_state;
    logic [9:0]  r_cnt;
    logic [2:0]  r_bit_idx;
    logic [7:0]  r_data;
    logic [1:0]  r_last_grant;
    logic [1:0]  r_grant_id;
    logic        r_txd;
    logic        r_busy;

    state_t      w_state_next;
    logic [9:0]  w_cnt_next;
    logic [2:0]  w_bit_idx_next;
    logic        w_txd_next;
    logic [1:0]  w_winner;
    logic        w_found;
    logic        w_bit_done;
    logic        w_accept;

    // Round-robin search starting just after the previous winner; the 2-bit add wraps mod 4.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        w_winner = r_last_grant;
        w_found  = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            if (!w_found && req_valid[r_last_grant + 2'(k)]) begin
                w_winner = r_last_grant + 2'(k);
                w_found  = 1'b1;
            end
        end
    end

    assign w_bit_done = (r_cnt == LAST_CNT);
    // rst_n is folded in so no byte is ever acknowledged while the block is being reset.
    assign w_accept   = rst_n && w_found &&
                        ((r_state == S_IDLE) || ((r_state == S_STOP) && w_bit_done));
    assign req_ready  = w_accept ? (4'b0001 << w_winner) : 4'b0000;

    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = w_bit_done ? 10'd0 : r_cnt + 10'd1;
        w_bit_idx_next = r_bit_idx;
        case (r_state)
            S_IDLE: begin
                w_cnt_next = 10'd0;
            end
            S_START: begin
                if (w_bit_done) begin
                    w_state_next   = S_DATA;
                    w_bit_idx_next = 3'd0;
                end
            end
            S_DATA: begin
                if (w_bit_done) begin
                    if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_ARB_PARITY_EN
                        w_state_next = S_PARITY;
`else
                        w_state_next = S_STOP;
`endif
                    end else begin
                        w_bit_idx_next = r_bit_idx + 3'd1;
                    end
                end
            end
`ifdef UART_TX_ARB_PARITY_EN
            S_PARITY: begin
                if (w_bit_done) w_state_next = S_STOP;
            end
`endif
            S_STOP: begin
                if (w_bit_done) w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
                w_cnt_next   = 10'd0;
            end
        endcase

        // An accept in the last STOP cycle overrides the return to IDLE: no gap between frames.
        if (w_accept) begin
            w_state_next = S_START;
            w_cnt_next   = 10'd0;
        end
    end

    // The line level is decoded from the next state so txd comes straight off a flop.
    always_comb begin
        w_txd_next = 1'b1;
        case (w_state_next)
            S_START:  w_txd_next = 1'b0;
            S_DATA:   w_txd_next = r_data[w_bit_idx_next];
`ifdef UART_TX_ARB_PARITY_EN
            S_PARITY: w_txd_next = ^r_data;
`endif
            default:  w_txd_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= 10'd0;
            r_bit_idx    <= 3'd0;
            r_data       <= 8'd0;
            r_last_grant <= 2'd3;
            r_grant_id   <= 2'd0;
            r_txd        <= 1'b1;
            r_busy       <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_bit_idx <= w_bit_idx_next;
            r_txd     <= w_txd_next;
            r_busy    <= (w_state_next != S_IDLE);
            if (w_accept) begin
                r_data       <= req_data[{w_winner, 3'b000} +: 8];
                r_grant_id   <= w_winner;
                r_last_grant <= w_winner;
            end
        end
    end

    assign txd      = r_txd;
    assign busy     = r_busy;
    assign grant_id = r_grant_id;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter at CLK_DIV=4: vector table, corner sequences,
// and random traffic against a round-robin / frame-shape reference model.
module tb_uart_tx_arbiter;

    localparam int CLK_DIV = 4;
`ifdef UART_TX_ARB_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME_CLKS = FRAME_BITS * CLK_DIV;
    localparam int NB         = 5 * FRAME_CLKS + 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req_valid = 4'b0;
    logic [31:0] req_data = 32'b0;
    logic [3:0]  req_ready;
    logic [1:0]  grant_id;
    logic        busy;
    logic        txd;

    int          n_checks = 0;
    int          n_err = 0;
    logic [1:0]  m_last = 2'd3;

    uart_tx_arbiter #(.CLK_DIV(CLK_DIV)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .grant_id  (grant_id),
        .busy      (busy),
        .txd       (txd)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [3:0]  valid;
        logic [31:0] data;
        logic [1:0]  exp_grant;
        logic [7:0]  exp_byte;
    } vec_t;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
        end
    endtask

    function automatic logic [1:0] rr_pick(input logic [3:0] mask, input logic [1:0] last);
        int idx;
        for (int k = 1; k <= 4; k++) begin
            idx = (int'(last) + k) % 4;
            if (mask[idx]) return 2'(idx);
        end
        return last;
    endfunction

    // Expected txd, one entry per clock of the frame, index 0 = first START clock.
    function automatic logic [63:0] frame_samples(input logic [7:0] b);
        logic [63:0]           v;
        logic [FRAME_BITS-1:0] fb;
        v     = '0;
        fb    = '0;
        fb[0] = 1'b0;
        for (int j = 0; j < 8; j++) fb[1 + j] = b[j];
`ifdef UART_TX_ARB_PARITY_EN
        fb[9]  = ^b;
        fb[10] = 1'b1;
`else
        fb[9]  = 1'b1;
`endif
        for (int i = 0; i < FRAME_CLKS; i++) v[i] = fb[i / CLK_DIV];
        return v;
    endfunction

    // Called just after the accept edge; samples every clock of the frame at the negedge.
    task automatic capture_frame(input string name, input logic [7:0] b,
                                 input logic [1:0] gid, input bit expect_idle);
        logic [63:0] got;
        int          busy_n;
        logic [3:0]  ready_or;
        logic [1:0]  g0;
        got      = '0;
        busy_n   = 0;
        ready_or = '0;
        g0       = '0;
        for (int i = 0; i < FRAME_CLKS; i++) begin
            @(negedge clk);
            got[i]   = txd;
            busy_n  += int'(busy);
            ready_or = ready_or | req_ready;
            if (i == 0) g0 = grant_id;
        end
        check({name, "_grant"}, 64'(g0), 64'(gid));
        check({name, "_txd"}, got, frame_samples(b));
        check({name, "_busy_len"}, 64'(busy_n), 64'(FRAME_CLKS));
        check({name, "_ready_quiet"}, 64'(ready_or), 64'd0);
        m_last = gid;
        if (expect_idle) begin
            @(negedge clk);
            check({name, "_idle"}, {62'd0, busy, txd}, 64'b01);
            check({name, "_grant_hold"}, 64'(grant_id), 64'(gid));
        end
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1 rst_n = 1'b0;
        req_valid = 4'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        m_last = 2'd3;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        @(negedge clk);
        while (busy !== 1'b0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) check("wait_idle_timeout", 64'(busy), 64'd0);
    endtask

    vec_t        vecs[9];
    int          gs[$];
    logic [3:0]  gr[$];
    logic        txd_s[NB];

    initial begin
        vecs[0] = '{4'b0001, 32'h0000_0041, 2'd0, 8'h41};
        vecs[1] = '{4'b1010, 32'hA500_5A00, 2'd1, 8'h5A};
        vecs[2] = '{4'b1010, 32'hC300_3C00, 2'd3, 8'hC3};
        vecs[3] = '{4'b0110, 32'h00FF_8000, 2'd1, 8'h80};
        vecs[4] = '{4'b1111, 32'h01FE_0203, 2'd2, 8'hFE};
        vecs[5] = '{4'b0001, 32'h0000_0000, 2'd0, 8'h00};
        vecs[6] = '{4'b1100, 32'hFF55_0000, 2'd2, 8'h55};
        vecs[7] = '{4'b0100, 32'h0007_0000, 2'd2, 8'h07};
        vecs[8] = '{4'b0001, 32'h0000_0003, 2'd0, 8'h03};

        // Reset state, with requests pending that must not be acknowledged.
        req_valid = 4'b1111;
        repeat (3) @(negedge clk);
        check("reset_outputs", {58'd0, req_ready, grant_id}, 64'd0);
        check("reset_line", {62'd0, busy, txd}, 64'b01);
        @(posedge clk);
        #1 req_valid = 4'b0;
        rst_n = 1'b1;
        m_last = 2'd3;

        // Table of single frames launched from IDLE.
        for (int i = 0; i < 9; i++) begin
            @(posedge clk);
            #1 req_valid = vecs[i].valid;
            req_data = vecs[i].data;
            @(negedge clk);
            check($sformatf("vec%0d_ready", i), 64'(req_ready), 64'(4'b0001 << vecs[i].exp_grant));
            @(posedge clk);
            #1 req_valid = 4'b0;
            capture_frame($sformatf("vec%0d", i), vecs[i].exp_byte, vecs[i].exp_grant, 1'b1);
        end

        // Requester 2 arrives one cycle before and in the last STOP cycle.
        @(posedge clk);
        #1 req_valid = 4'b0001;
        req_data = 32'h00B7_005E;
        @(negedge clk);
        check("stopacc_first_ready", 64'(req_ready), 64'b0001);
        @(posedge clk);
        #1 req_valid = 4'b0;
        repeat (FRAME_CLKS - 2) @(posedge clk);
        #1 req_valid = 4'b0100;
        @(negedge clk);
        check("stopacc_early_ready", 64'(req_ready), 64'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("stopacc_final_ready", 64'(req_ready), 64'b0100);
        check("stopacc_final_line", {62'd0, busy, txd}, 64'b11);
        @(posedge clk);
        #1 req_valid = 4'b0;
        capture_frame("stopacc_req2", 8'hB7, 2'd2, 1'b1);

        // Reset in the middle of DATA bit 3.
        @(posedge clk);
        #1 req_valid = 4'b0010;
        req_data = 32'h0000_A600;
        @(negedge clk);
        check("midrst_ready", 64'(req_ready), 64'(4'b0001 << rr_pick(4'b0010, m_last)));
        @(posedge clk);
        #1 req_valid = 4'b0;
        repeat (4 * CLK_DIV + 1) @(posedge clk);
        #1 rst_n = 1'b0;
        req_valid = 4'b1001;
        req_data = 32'h3C00_00C5;
        @(negedge clk);
        check("midrst_bit3", {62'd0, busy, txd}, {62'd0, 1'b1, 1'b0});
        check("midrst_no_ready", 64'(req_ready), 64'd0);
        @(posedge clk);
        @(negedge clk);
        check("midrst_outputs", {58'd0, req_ready, grant_id}, 64'd0);
        check("midrst_line", {62'd0, busy, txd}, 64'b01);
        @(posedge clk);
        #1 rst_n = 1'b1;
        m_last = 2'd3;
        @(negedge clk);
        check("postrst_ready", 64'(req_ready), 64'b0001);
        @(posedge clk);
        #1 req_valid = 4'b0;
        capture_frame("postrst", 8'hC5, 2'd0, 1'b1);

        // All four requesters held valid: continuous back-to-back frames.
        apply_reset();
        @(posedge clk);
        #1 req_valid = 4'b1111;
        req_data = 32'h4433_2211;
        for (int n = 0; n < NB; n++) begin
            @(negedge clk);
            txd_s[n] = txd;
            if (req_ready != 4'b0) begin
                gs.push_back(n);
                gr.push_back(req_ready);
            end
        end
        @(posedge clk);
        #1 req_valid = 4'b0;
        check("b2b_grant_count", 64'(gs.size() >= 5), 64'd1);
        for (int k = 0; k < 5; k++) begin
            if (k < gs.size()) begin
                int         s;
                logic [1:0] eg;
                logic [7:0] got_b;
                s     = gs[k];
                eg    = 2'(k % 4);
                got_b = '0;
                for (int j = 0; j < 8; j++)
                    got_b[j] = txd_s[s + 1 + CLK_DIV * (1 + j) + CLK_DIV / 2];
                check($sformatf("b2b%0d_ready", k), 64'(gr[k]), 64'(4'b0001 << eg));
                check($sformatf("b2b%0d_edge", k), {62'd0, txd_s[s], txd_s[s + 1]}, 64'b10);
                check($sformatf("b2b%0d_byte", k), 64'(got_b), 64'(8'h11 * (int'(eg) + 1)));
                if (k > 0)
                    check($sformatf("b2b%0d_period", k), 64'(gs[k] - gs[k - 1]), 64'(FRAME_CLKS));
            end
        end
        wait_idle();

        // Random single-frame traffic against the round-robin model.
        apply_reset();
        for (int it = 0; it < 20; it++) begin
            logic [3:0]  mask;
            logic [31:0] data;
            logic [1:0]  eg;
            mask = 4'($urandom_range(1, 15));
            data = $urandom;
            eg   = rr_pick(mask, m_last);
            @(posedge clk);
            #1 req_valid = mask;
            req_data = data;
            @(negedge clk);
            check($sformatf("rnd%0d_ready", it), 64'(req_ready), 64'(4'b0001 << eg));
            @(posedge clk);
            #1 req_valid = 4'b0;
            capture_frame($sformatf("rnd%0d", it), data[int'(eg) * 8 +: 8], eg, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
